// File: rtl/prbs_qpsk_sym_source.sv
// PRBS9 I/Q antipodal impulse source, zero-stuffed to OVERSAMP; symbol n on enabled edge n*OVERSAMP+1.
// No backpressure: i_enable low freezes all state and zeroes strobes/impulses; macro PRBS_TX_ERR_INJ_EN adds I-error injection.
module prbs_qpsk_sym_source #(
  parameter logic [8:0] PRBS_SEED_I     = 9'h1AA,
  parameter logic [8:0] PRBS_SEED_Q     = 9'h1FE,
  parameter int         OVERSAMP        = 4,
  parameter int         PRBS_MAX_CYCLES = 511,
  parameter int         NB_CNT          = 64
`ifdef PRBS_TX_ERR_INJ_EN
  , parameter int       ERR_PERIOD      = 100
`endif
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic                        i_enable,
`ifdef PRBS_TX_ERR_INJ_EN
  input  logic                        i_err_inj,
  output logic [NB_CNT-1:0]           o_err_count,
`endif
  output logic                        o_sym_I,
  output logic                        o_sym_Q,
  output logic signed [1:0]           o_up_I,
  output logic signed [1:0]           o_up_Q,
  output logic                        o_sym_valid,
  output logic [$clog2(OVERSAMP)-1:0] o_phase,
  output logic                        o_period_start,
  output logic [NB_CNT-1:0]           o_sym_count
);

  localparam int PW = $clog2(OVERSAMP);
  localparam int IW = (PRBS_MAX_CYCLES > 1) ? $clog2(PRBS_MAX_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMP - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(PRBS_MAX_CYCLES - 1);
  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [8:0] SEED_I = (PRBS_SEED_I == 9'd0) ? 9'h1FF : PRBS_SEED_I;
  localparam logic [8:0] SEED_Q = (PRBS_SEED_Q == 9'd0) ? 9'h1FF : PRBS_SEED_Q;

  logic [8:0]    lfsr_i;
  logic [8:0]    lfsr_q;
  logic [PW-1:0] r_phase;
  logic [IW-1:0] sym_idx;
  logic          sym_edge;
  logic          inj_now;
  logic          bit_i;
  logic          bit_q;

  assign sym_edge = i_enable && (r_phase == '0);
  assign bit_i    = lfsr_i[8] ^ inj_now;
  assign bit_q    = lfsr_q[8];

`ifdef PRBS_TX_ERR_INJ_EN
  localparam int EW = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;
  localparam logic [EW-1:0] INJ_LAST = EW'(ERR_PERIOD - 1);

  logic [EW-1:0] inj_cnt;

  assign inj_now = i_err_inj && (inj_cnt == INJ_LAST);

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      inj_cnt     <= '0;
      o_err_count <= '0;
    end else if (!i_err_inj) begin
      inj_cnt <= '0;
    end else if (sym_edge) begin
      inj_cnt <= inj_now ? '0 : inj_cnt + 1'b1;
      if (inj_now && !(&o_err_count))
        o_err_count <= o_err_count + 1'b1;
    end
  end
`else
  assign inj_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      lfsr_i         <= SEED_I;
      lfsr_q         <= SEED_Q;
      r_phase        <= '0;
      sym_idx        <= '0;
      o_sym_I        <= 1'b0;
      o_sym_Q        <= 1'b0;
      o_up_I         <= 2'sb00;
      o_up_Q         <= 2'sb00;
      o_sym_valid    <= 1'b0;
      o_phase        <= '0;
      o_period_start <= 1'b0;
      o_sym_count    <= '0;
    end else if (i_enable) begin
      o_phase <= r_phase;
      r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
      if (sym_edge) begin
        lfsr_i         <= {lfsr_i[7:0], lfsr_i[8] ^ lfsr_i[4]};
        lfsr_q         <= {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
        o_sym_I        <= bit_i;
        o_sym_Q        <= bit_q;
        // Slicer convention: bit 0 -> +1, bit 1 -> -1.
        o_up_I         <= bit_i ? 2'sb11 : 2'sb01;
        o_up_Q         <= bit_q ? 2'sb11 : 2'sb01;
        o_sym_valid    <= 1'b1;
        o_period_start <= (sym_idx == '0);
        sym_idx        <= (sym_idx == IDX_LAST) ? '0 : sym_idx + 1'b1;
        if (!(&o_sym_count))
          o_sym_count <= o_sym_count + 1'b1;
      end else begin
        o_up_I         <= 2'sb00;
        o_up_Q         <= 2'sb00;
        o_sym_valid    <= 1'b0;
        o_period_start <= 1'b0;
      end
    end else begin
      o_up_I         <= 2'sb00;
      o_up_Q         <= 2'sb00;
      o_sym_valid    <= 1'b0;
      o_period_start <= 1'b0;
    end
  end

endmodule

// File: doc/prbs_qpsk_sym_source.md
Name: prbs_qpsk_sym_source

Overview:
Transmit-side symbol source that feeds the TX filter. It generates independent PRBS9 bit streams for I and Q and maps each bit to an antipodal ±1 impulse. The impulses are zero-stuffed to OVERSAMP samples per symbol, and a symbol strobe, period marker and symbol counter are provided. It is the generating end of the link whose far end is the BER checker (bit_error_counter). Both ends use the same PRBS9 polynomial and seeds, so the checker can synchronise and count errors.

Parameters:
PRBS_SEED_I, 9'h1AA, initial LFSR state for I; a value of 0 is replaced by 9'h1FF
PRBS_SEED_Q, 9'h1FE, initial LFSR state for Q; a value of 0 is replaced by 9'h1FF
OVERSAMP, 4, samples per symbol; must be >=2
PRBS_MAX_CYCLES, 511, PRBS period in symbols
NB_CNT, 64, width of the symbol counter

Ports:
clk  in  1  system clock
i_reset  in  1  asynchronous active-low reset
i_enable  in  1  run/freeze; when low, all state holds
o_sym_I  out  1  current I bit, updated on each o_sym_valid
o_sym_Q  out  1  current Q bit, updated on each o_sym_valid
o_up_I  out  2  signed zero-stuffed I impulse: 2'sb01 (+1), 2'sb11 (-1) or 2'sb00
o_up_Q  out  2  signed zero-stuffed Q impulse, same encoding
o_sym_valid  out  1  one-cycle strobe marking a new symbol (phase 0)
o_phase  out  $clog2(OVERSAMP)  sample phase within the current symbol
o_period_start  out  1  high together with o_sym_valid on symbol index 0 mod PRBS_MAX_CYCLES
o_sym_count  out  NB_CNT  number of symbols emitted, saturating

Behaviour:
- Reset (asynchronous, i_reset=0):
  - LFSRs load the seeds; the phase counter and symbol index are cleared to 0.
  - All outputs are 0.
  - Reset asserted mid-symbol aborts the symbol immediately.
- LFSR: PRBS9 x^9+x^5+1, register r[8:0].
  - Output bit = r[8].
  - Next state = {r[7:0], r[8]^r[4]}.
  - The LFSR advances only on symbol edges.
- Symbol edge: a rising clk edge with i_enable=1 and r_phase==0. On that edge:
  - o_sym_I <= rI[8] and o_sym_Q <= rQ[8]; both LFSRs shift.
  - o_sym_valid <= 1.
  - o_up_X <= (bit ? 2'sb11 : 2'sb01). Bit 0 maps to +1 and bit 1 maps to -1, matching the slicer convention.
  - o_period_start <= (sym_idx==0).
  - sym_idx <= (sym_idx==PRBS_MAX_CYCLES-1) ? 0 : sym_idx+1.
  - o_sym_count increments and saturates at all-ones.
- Other enabled edges:
  - o_sym_valid, o_period_start and o_up_X are driven to 0.
  - o_sym_I/Q hold their value.
- Phase counter:
  - 0 → OVERSAMP-1, then wraps to 0.
  - o_phase is the registered phase of the sample currently on o_up_X.
- Latency: the first enabled edge after reset release produces o_sym_valid=1 carrying the seed MSB. Symbol n appears on edge n*OVERSAMP+1 of uninterrupted enabled edges.
- i_enable low:
  - The phase, LFSRs, counters, o_sym_I/Q and o_phase all hold.
  - o_sym_valid, o_period_start and o_up_X are forced to 0.
  - On resume, the sequence continues from the held phase with no lost or duplicated symbols.
- i_enable toggling on the cycle that phase wraps: no symbol is emitted until an enabled edge with phase==0 occurs.

Optional Feature:
Macro PRBS_TX_ERR_INJ_EN.
- Defined:
  - Adds parameter ERR_PERIOD (default 100), input i_err_inj (1 bit) and output o_err_count (NB_CNT bits, saturating).
  - While i_err_inj=1, every ERR_PERIOD-th emitted symbol (injection counter == ERR_PERIOD-1) has o_sym_I and o_up_I inverted.
  - The LFSR is not affected by injection.
  - o_err_count increments once per injected error.
  - The injection counter runs only while i_err_inj=1 and clears when i_err_inj goes low or on reset.
- Undefined: the parameter, ports and logic are absent, and outputs are always the pure PRBS.

Test Plan:
1. Reset release with i_enable=1 held, OVERSAMP=4 → o_sym_valid on edges 1,5,9,…. First 9 I bits are 1,1,0,1,0,1,0,1,0 and first 9 Q bits are 1,1,1,1,1,1,1,1,0. o_up_I reads 11,00,00,00 for symbol 0.
2. Run 1100 symbols → symbol k equals symbol k+511 on both I and Q. o_period_start is high at indices 0, 511 and 1022 only. o_sym_count=1100.
3. Deassert i_enable for 7 cycles at phase 2 → outputs and o_phase hold, o_up_X=0. After resume, the bit sequence is identical to an uninterrupted run, shifted by 7 cycles.
4. Assert reset during phase 1 of symbol 300 → all outputs go to 0 asynchronously. After release, the first symbol is again 1 (I) and 1 (Q), and o_sym_count restarts from 1.
5. Loopback into bit_error_counter for 511*700 symbols → zero accumulated errors; bit_tot increments once per symbol.
6. With PRBS_TX_ERR_INJ_EN, ERR_PERIOD=100, i_err_inj=1 for 10000 symbols → exactly 100 I inversions, at symbols 99, 199, …. o_err_count=100. Q is error-free. The checker reports 100 I errors.
